// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the multi-input class router (arbitration modes, index-width helpers).
// Latency: none, compile-time constants and constant functions only.
// Backpressure: not applicable.
package arbitro_rr_pkg;

  // Arbitration policy selector values for the MODE parameter
  localparam int ARB_MODE_RR    = 0;
  localparam int ARB_MODE_FIXED = 1;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

  // Width of an index register for n entries, never less than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_rr_selector.sv
// Rotating priority picker: first set request at or after base, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller masks blocked requesters before they reach req.
module rr_selector
  import arbitro_rr_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [N-1:0] gnt,
  output logic         found
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_gnt;

  // Rotate so that base lands at bit 0, keep the lowest set bit, rotate back
  always_comb begin
    rot_req = N'({req, req} >> base);
    rot_gnt = rot_req & (~rot_req + N'(1));
    gnt     = N'(({rot_gnt, rot_gnt} << base) >> N);
    found   = |req;
  end

endmodule

// File: rtl/arbitro_rr.sv
// Arbitrates N_IN show-ahead input FIFOs and routes each popped word by its class field to an output FIFO.
// Latency: pop/push/data_out are registered one cycle after the flags they were decided from.
// Backpressure: a word is held only when its own destination asserts almost_full; other inputs keep flowing.
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 4,
  parameter int DATA_W    = 6,
  parameter int CLASS_W   = 2,
  parameter int CLASS_LSB = 4,
  parameter int MODE      = ARB_MODE_RR,
  parameter int DROP_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [N_IN-1:0]          fifo_empty,
  input  logic [N_IN*DATA_W-1:0]   fifo_data,
  input  logic [N_OUT-1:0]         almost_full,
  output logic [N_IN-1:0]          pop,
  output logic [N_OUT-1:0]         push,
  output logic [DATA_W-1:0]        data_out,
  output logic                     idle,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int PTR_W = idx_w(N_IN);

  logic [CLASS_W-1:0] dest    [N_IN];
  logic [N_IN-1:0]    valid;
  logic [N_IN-1:0]    blocked;
  logic [N_IN-1:0]    elig;

  logic [N_IN-1:0]    gnt;
  logic               found;
  logic [PTR_W-1:0]   ptr;

  logic [DATA_W-1:0]  sel_data;
  logic [CLASS_W-1:0] sel_dest;
  logic               sel_valid;
  logic [N_OUT-1:0]   push_nxt;

  // Per-input decode: destination class, class validity, destination stall and eligibility.
  // A head popped last cycle (pop still high) is not yet replaced, so it must not be granted again.
  always_comb begin
    valid   = '0;
    blocked = '0;
    elig    = '0;
    for (int i = 0; i < N_IN; i++) begin
      dest[i]  = fifo_data[i*DATA_W + CLASS_LSB +: CLASS_W];
      valid[i] = (int'(dest[i]) < N_OUT);
      for (int k = 0; k < N_OUT; k++) begin
        if ((dest[i] == CLASS_W'(k)) && almost_full[k]) begin
          blocked[i] = 1'b1;
        end
      end
      elig[i] = !fifo_empty[i] && !pop[i] && (!valid[i] || !blocked[i]);
    end
  end

  rr_selector #(
    .N (N_IN),
    .W (PTR_W)
  ) u_sel (
    .req   (elig),
    .base  (ptr),
    .gnt   (gnt),
    .found (found)
  );

  generate
    if ((MODE == ARB_MODE_RR) && (N_IN > 1)) begin : g_rr_ptr
      logic [PTR_W-1:0] g_idx;

      // Binary index of the granted input, used to advance the pointer past it
      always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
          if (gnt[i]) begin
            g_idx = PTR_W'(i);
          end
        end
      end

      // Pointer moves to the input after the winner; holds when nothing is granted
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          ptr <= '0;
        end else if (found) begin
          ptr <= (g_idx == PTR_W'(N_IN - 1)) ? '0 : g_idx + PTR_W'(1);
        end
      end
    end else begin : g_fixed_ptr
      // Fixed priority, or a single input: the scan always starts at input 0
      assign ptr = '0;
    end
  endgenerate

  // Word, class and validity of the granted input (gnt is one-hot or zero)
  always_comb begin
    sel_data  = '0;
    sel_dest  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt[i]) begin
        sel_data  = sel_data  | fifo_data[i*DATA_W +: DATA_W];
        sel_dest  = sel_dest  | dest[i];
        sel_valid = sel_valid | valid[i];
      end
    end
  end

  // One-hot push toward the granted word's class; invalid classes push nothing
  always_comb begin
    push_nxt = '0;
    for (int k = 0; k < N_OUT; k++) begin
      push_nxt[k] = found && sel_valid && (sel_dest == CLASS_W'(k));
    end
  end

  // Registered outputs and saturating drop counter; reset discards any pending pop/push
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop      <= '0;
      push     <= '0;
      data_out <= '0;
      idle     <= 1'b1;
      drop_cnt <= '0;
    end else begin
      pop  <= gnt;
      push <= push_nxt;
      idle <= (&fifo_empty) && !found;
      if (found) begin
        data_out <= sel_data;
      end
      if (found && !sel_valid && !(&drop_cnt)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule
